// File: rtl/spi_slave_responder.sv
// SPI mode-0 target: oversamples the link on clock_in, receives mosi into rx_data and
// shifts a buffered tx word out on miso (MSB first), with back-to-back words while selected.
module spi_slave_responder #(
    parameter int unsigned          DATA_W      = 8,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0]    IDLE_BYTE   = 8'hFF
) (
    input  logic              clock_in,
    input  logic              rs,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_abort,
    output logic              tx_underrun
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_ACTIVE    = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_rx_q, shift_rx_d;
    logic [DATA_W-1:0] shift_tx_q, shift_tx_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic              reload_pend_q, reload_pend_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_abort_q, rx_abort_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              load_c, wr_c;

    // Link synchronisers; cs resets to "selected" so a frame in progress at reset release is ignored.
    always_ff @(posedge clock_in or posedge rs) begin
        if (rs) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise_c = sclk_s & ~sclk_prev_q;
    assign sclk_fall_c = ~sclk_s & sclk_prev_q;
    assign cs_rise_c   = cs_s & ~cs_prev_q;
    assign cs_fall_c   = ~cs_s & cs_prev_q;

    always_ff @(posedge clock_in or posedge rs) begin
        if (rs) begin
            state_q       <= ST_WAIT_IDLE;
            bit_cnt_q     <= '0;
            shift_rx_q    <= '0;
            shift_tx_q    <= IDLE_BYTE;
            buf_q         <= '0;
            buf_full_q    <= 1'b0;
            reload_pend_q <= 1'b0;
            miso_q        <= IDLE_BYTE[DATA_W-1];
            miso_oe_q     <= 1'b0;
            tx_ready_q    <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_abort_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_rx_q    <= shift_rx_d;
            shift_tx_q    <= shift_tx_d;
            buf_q         <= buf_d;
            buf_full_q    <= buf_full_d;
            reload_pend_q <= reload_pend_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            tx_ready_q    <= tx_ready_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_abort_q    <= rx_abort_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    // Next state: cs changes take priority over any sclk edge seen in the same cycle.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_rx_d    = shift_rx_q;
        shift_tx_d    = shift_tx_q;
        buf_d         = buf_q;
        buf_full_d    = buf_full_q;
        reload_pend_d = reload_pend_q;
        miso_d        = miso_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_abort_d    = 1'b0;
        tx_underrun_d = 1'b0;
        load_c        = 1'b0;
        wr_c          = tx_valid & tx_ready_q;

        case (state_q)
            ST_WAIT_IDLE: begin
                if (cs_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall_c) begin
                    load_c        = 1'b1;
                    bit_cnt_d     = '0;
                    reload_pend_d = 1'b0;
                    state_d       = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise_c) begin
                    state_d       = ST_IDLE;
                    rx_abort_d    = (bit_cnt_q != '0);
                    bit_cnt_d     = '0;
                    reload_pend_d = 1'b0;
                    shift_rx_d    = '0;
                end else if (sclk_rise_c) begin
                    shift_rx_d = {shift_rx_q[DATA_W-2:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_data_d     = {shift_rx_q[DATA_W-2:0], mosi_s};
                        rx_valid_d    = 1'b1;
                        bit_cnt_d     = '0;
                        reload_pend_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall_c) begin
                    if (reload_pend_q) begin
                        load_c        = 1'b1;
                        reload_pend_d = 1'b0;
                    end else begin
                        shift_tx_d = {shift_tx_q[DATA_W-2:0], 1'b0};
                        miso_d     = shift_tx_q[DATA_W-2];
                    end
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase

        // Word load: buffer first, then a same-cycle bypass of tx_data, else the idle word.
        if (load_c) begin
            if (buf_full_q) begin
                shift_tx_d = buf_q;
                buf_full_d = 1'b0;
            end else if (tx_valid) begin
                shift_tx_d = tx_data;
                wr_c       = 1'b0;
            end else begin
                shift_tx_d    = IDLE_BYTE;
                tx_underrun_d = 1'b1;
            end
            miso_d = shift_tx_d[DATA_W-1];
        end

        if (wr_c) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end

        miso_oe_d  = (state_d == ST_ACTIVE);
        tx_ready_d = ~buf_full_d;
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_abort    = rx_abort_q;
    assign tx_underrun = tx_underrun_q;

endmodule
